// File: rtl/blvds_link_responder_if.sv
// Signal bundle between the BLVDS link responder and the host logic around it.
// slave is the responder side; master is the host/buffer side.
interface blvds_link_responder_if;
    logic        din;
    logic        oe;
    logic        doutp;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_err;
    logic        tmo;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;

    modport slave (
        input  din, tx_data, tx_valid,
        output oe, doutp, rx_data, rx_valid, rx_err, tmo, tx_ready, busy
    );

    modport master (
        output din, tx_data, tx_valid,
        input  oe, doutp, rx_data, rx_valid, rx_err, tmo, tx_ready, busy
    );
endinterface

// File: rtl/blvds_link_responder.sv
// Half-duplex BLVDS command/response responder: receives a 16-bit command frame,
// waits for a response word, then drives it back after a bus-turnaround gap.
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | line idle; hunt_q qualifies a start bit at its mid-point
// S_RX_BITS   | sampling 16 data bits and the stop bit at mid-bit
// S_WAIT_RESP | tx_ready high, waiting for a response or the timeout
// S_GAP       | turnaround idle before driving the line
// S_TX_BITS   | driving start, 16 data bits MSB first, stop
module blvds_link_responder #(
    parameter int CLKS_PER_BIT = 4,
    parameter int GAP_BITS     = 2,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    blvds_link_responder_if.slave bus
);
    localparam int TMO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GAP_CYC = GAP_BITS * CLKS_PER_BIT;
    localparam int TMR_M1  = (TMO_CYC > GAP_CYC) ? TMO_CYC : GAP_CYC;
    localparam int TMR_MAX = (TMR_M1 > CLKS_PER_BIT) ? TMR_M1 : CLKS_PER_BIT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX_BITS,
        S_WAIT_RESP,
        S_GAP,
        S_TX_BITS
    } state_t;

    state_t           state_q;
    logic             sync1_q;
    logic             dsync_q;
    logic             dsync_prev_q;
    logic             hunt_q;
    logic [TMR_W-1:0] tmr_q;
    logic [4:0]       bit_q;
    logic [15:0]      rx_sh_q;
    logic [15:0]      rx_data_q;
    logic [17:0]      tx_sh_q;
    logic             oe_q;
    logic             doutp_q;
    logic             tx_ready_q;
    logic             busy_q;
    logic             rx_valid_q;
    logic             rx_err_q;
    logic             tmo_q;

    logic             tmr_tc;
    logic             dsync_rise;
    logic             handshake;
    logic [TMR_W-1:0] tmr_dec;

    assign tmr_tc     = (tmr_q == '0);
    assign tmr_dec    = tmr_q - TMR_W'(1);
    assign dsync_rise = dsync_q & ~dsync_prev_q;
    assign handshake  = tx_ready_q & bus.tx_valid;

    // Our own transmission must never look like an incoming frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q      <= 1'b0;
            dsync_q      <= 1'b0;
            dsync_prev_q <= 1'b0;
        end else begin
            sync1_q      <= bus.din & ~oe_q;
            dsync_q      <= sync1_q;
            dsync_prev_q <= dsync_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hunt_q     <= 1'b0;
            tmr_q      <= '0;
            bit_q      <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            tx_sh_q    <= '0;
            oe_q       <= 1'b0;
            doutp_q    <= 1'b0;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            tmo_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (hunt_q) begin
                        if (tmr_tc) begin
                            hunt_q <= 1'b0;
                            if (dsync_q) begin
                                state_q <= S_RX_BITS;
                                busy_q  <= 1'b1;
                                tmr_q   <= TMR_W'(CLKS_PER_BIT - 1);
                                bit_q   <= 5'd16;
                            end
                        end else begin
                            tmr_q <= tmr_dec;
                        end
                    end else if (dsync_rise) begin
                        hunt_q <= 1'b1;
                        tmr_q  <= TMR_W'(CLKS_PER_BIT / 2 - 1);
                    end
                end

                S_RX_BITS: begin
                    if (!tmr_tc) begin
                        tmr_q <= tmr_dec;
                    end else if (bit_q != 5'd0) begin
                        rx_sh_q <= {rx_sh_q[14:0], dsync_q};
                        bit_q   <= bit_q - 5'd1;
                        tmr_q   <= TMR_W'(CLKS_PER_BIT - 1);
                    end else if (!dsync_q) begin
                        rx_data_q  <= rx_sh_q;
                        rx_valid_q <= 1'b1;
                        state_q    <= S_WAIT_RESP;
                        tmr_q      <= TMR_W'(TMO_CYC);
                    end else begin
                        rx_err_q <= 1'b1;
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                    end
                end

                // Entry cycle carries rx_valid; tx_ready opens on the cycle after,
                // so the timer is loaded one count long to give a full window.
                S_WAIT_RESP: begin
                    if (handshake) begin
                        tx_sh_q    <= {1'b1, bus.tx_data, 1'b0};
                        tx_ready_q <= 1'b0;
                        state_q    <= S_GAP;
                        tmr_q      <= TMR_W'(GAP_CYC - 1);
                    end else if (tmr_tc) begin
                        tmo_q      <= 1'b1;
                        tx_ready_q <= 1'b0;
                        state_q    <= S_IDLE;
                        busy_q     <= 1'b0;
                    end else begin
                        tx_ready_q <= 1'b1;
                        tmr_q      <= tmr_dec;
                    end
                end

                S_GAP: begin
                    if (tmr_tc) begin
                        state_q <= S_TX_BITS;
                        oe_q    <= 1'b1;
                        doutp_q <= tx_sh_q[17];
                        tx_sh_q <= {tx_sh_q[16:0], 1'b0};
                        bit_q   <= 5'd17;
                        tmr_q   <= TMR_W'(CLKS_PER_BIT - 1);
                    end else begin
                        tmr_q <= tmr_dec;
                    end
                end

                S_TX_BITS: begin
                    if (!tmr_tc) begin
                        tmr_q <= tmr_dec;
                    end else if (bit_q != 5'd0) begin
                        doutp_q <= tx_sh_q[17];
                        tx_sh_q <= {tx_sh_q[16:0], 1'b0};
                        bit_q   <= bit_q - 5'd1;
                        tmr_q   <= TMR_W'(CLKS_PER_BIT - 1);
                    end else begin
                        oe_q    <= 1'b0;
                        doutp_q <= 1'b0;
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q    <= S_IDLE;
                    hunt_q     <= 1'b0;
                    oe_q       <= 1'b0;
                    doutp_q    <= 1'b0;
                    tx_ready_q <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oe       = oe_q;
    assign bus.doutp    = doutp_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_err   = rx_err_q;
    assign bus.tmo      = tmo_q;
    assign bus.tx_ready = tx_ready_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_blvds_link_responder.sv
// Directed bench for blvds_link_responder: stimulus pushes expected events into a
// queue and an independent monitor pops and checks them as the DUT produces them.
module tb_blvds_link_responder;
    localparam int CPB     = 4;
    localparam int GAPB    = 2;
    localparam int TMOB    = 64;
    localparam int EV_RX   = 1;
    localparam int EV_ERR  = 2;
    localparam int EV_TMO  = 3;
    localparam int EV_TX   = 4;
    localparam int EV_ABRT = 5;

    typedef struct {
        int          kind;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    blvds_link_responder_if bus ();

    blvds_link_responder #(
        .CLKS_PER_BIT(CPB),
        .GAP_BITS    (GAPB),
        .TIMEOUT_BITS(TMOB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic push_exp(input int kind, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pop_exp(input int kind, output exp_t e);
        if (exp_q.size() == 0) begin
            e.kind = 0;
            e.data = '0;
            total++;
            bad++;
            $display("FAIL unexpected_event: got kind %0d expected none", kind);
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", kind, e.kind);
        end
    endtask

    task automatic send_frame(input logic [15:0] w, input logic stop_bit);
        logic [17:0] f;
        f = {1'b1, w, stop_bit};
        @(posedge clk);
        #1;
        for (int i = 17; i >= 0; i--) begin
            bus.din = f[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        bus.din = 1'b0;
    endtask

    // sel: 0 rx_valid, 1 oe, 2 tmo, 3 busy low, 4 rx_err
    task automatic wait_for(input int sel, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            case (sel)
                0:       hit = bus.rx_valid;
                1:       hit = bus.oe;
                2:       hit = bus.tmo;
                4:       hit = bus.rx_err;
                default: hit = !bus.busy;
            endcase
        end
        chk(name, {31'd0, hit}, 32'd1);
    endtask

    task automatic respond_next(input logic [15:0] w);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = w;
        @(negedge clk);
        chk("tx_ready_after_rx_valid", {31'd0, bus.tx_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
    endtask

    // Monitor: pops one expectation per DUT event.
    bit          oe_prev = 1'b0;
    bit          rxv_prev = 1'b0;
    bit          txr_prev = 1'b0;
    int          hs_cyc = 0;
    int          txr_rise = 0;

    initial begin : monitor
        exp_t        e;
        int          kind;
        int          gap;
        int          len;
        logic [17:0] frame;
        forever begin
            @(negedge clk);
            if (bus.tx_valid && bus.tx_ready) hs_cyc = cyc;
            if (bus.tx_ready && !txr_prev) txr_rise = cyc;
            if (bus.rx_valid) begin
                chk("rx_valid_pulse", {31'd0, rxv_prev}, 32'd0);
                pop_exp(EV_RX, e);
                chk("rx_data", {16'd0, bus.rx_data}, {16'd0, e.data});
            end
            if (bus.rx_err) begin
                pop_exp(EV_ERR, e);
                chk("err_rx_data_kept", {16'd0, bus.rx_data}, {16'd0, e.data});
            end
            if (bus.tmo) begin
                pop_exp(EV_TMO, e);
                chk("tmo_delay", cyc - txr_rise, TMOB * CPB);
            end
            if (bus.oe && !oe_prev) begin
                kind = (exp_q.size() > 0 && exp_q[0].kind == EV_ABRT) ? EV_ABRT : EV_TX;
                pop_exp(kind, e);
                gap   = cyc - hs_cyc;
                len   = 0;
                frame = '0;
                while (bus.oe && len < 200) begin
                    if (len % CPB == CPB / 2) frame = {frame[16:0], bus.doutp};
                    len++;
                    @(negedge clk);
                end
                if (kind == EV_TX) begin
                    chk("tx_gap", gap, GAPB * CPB + 1);
                    chk("tx_oe_len", len, 18 * CPB);
                    chk("tx_frame", {14'd0, frame}, {14'd0, 1'b1, e.data, 1'b0});
                    chk("after_tx_busy_doutp", {30'd0, bus.busy, bus.doutp}, 32'd0);
                end
            end
            oe_prev  = bus.oe;
            rxv_prev = bus.rx_valid;
            txr_prev = bus.tx_ready;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        bit maxb;
        bus.din      = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        rst          = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {9'd0, bus.oe, bus.doutp, bus.tx_ready, bus.busy, bus.rx_valid,
                            bus.rx_err, bus.tmo, bus.rx_data}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_state", {9'd0, bus.oe, bus.doutp, bus.tx_ready, bus.busy, bus.rx_valid,
                                 bus.rx_err, bus.tmo, bus.rx_data}, 32'd0);

        // Valid command then immediate response.
        push_exp(EV_RX, 16'hA5C3);
        push_exp(EV_TX, 16'h3C5A);
        send_frame(16'hA5C3, 1'b0);
        wait_for(0, "wait_rx_valid_a");
        respond_next(16'h3C5A);
        wait_for(3, "wait_idle_a");

        // Stop bit 1: framing error, rx_data keeps A5C3.
        push_exp(EV_ERR, 16'hA5C3);
        send_frame(16'h1234, 1'b1);
        wait_for(4, "wait_rx_err");
        chk("err_idle", {30'd0, bus.busy, bus.tx_ready}, 32'd0);

        // Short glitch in IDLE.
        @(posedge clk);
        #1;
        bus.din = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.din = 1'b0;
        maxb = 1'b0;
        repeat (12) begin
            @(negedge clk);
            maxb = maxb | bus.busy;
        end
        chk("glitch_busy", {31'd0, maxb}, 32'd0);

        // No response: timeout.
        push_exp(EV_RX, 16'h0F0F);
        push_exp(EV_TMO, 16'h0000);
        send_frame(16'h0F0F, 1'b0);
        wait_for(0, "wait_rx_valid_t");
        wait_for(2, "wait_tmo");
        chk("tmo_ready_busy_low", {30'd0, bus.tx_ready, bus.busy}, 32'd0);
        @(negedge clk);
        chk("tmo_ready_stays_low", {31'd0, bus.tx_ready}, 32'd0);

        // Response arriving on the expiry cycle wins.
        push_exp(EV_RX, 16'h1357);
        push_exp(EV_TX, 16'h2468);
        send_frame(16'h1357, 1'b0);
        wait_for(0, "wait_rx_valid_r");
        repeat (TMOB * CPB) @(posedge clk);
        #1;
        bus.tx_valid = 1'b1;
        bus.tx_data  = 16'h2468;
        @(negedge clk);
        chk("race_ready_no_tmo", {30'd0, bus.tx_ready, bus.tmo}, 32'd2);
        @(posedge clk);
        #1;
        bus.tx_valid = 1'b0;
        @(negedge clk);
        chk("race_gap_entered", {28'd0, bus.busy, bus.oe, bus.tx_ready, bus.tmo}, 32'h8);
        wait_for(3, "wait_idle_r");

        // Reset during the 5th data bit of a transmission.
        push_exp(EV_RX, 16'h00FF);
        push_exp(EV_ABRT, 16'hF8F8);
        send_frame(16'h00FF, 1'b0);
        wait_for(0, "wait_rx_valid_x");
        respond_next(16'hF8F8);
        wait_for(1, "wait_oe_x");
        repeat (5 * CPB + 1) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("tx_bit5_level", {30'd0, bus.oe, bus.doutp}, 32'd3);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_tx", {28'd0, bus.oe, bus.doutp, bus.busy, bus.tx_ready}, 32'd0);

        // Normal exchange after the reset.
        push_exp(EV_RX, 16'h5AA5);
        push_exp(EV_TX, 16'h1111);
        send_frame(16'h5AA5, 1'b0);
        wait_for(0, "wait_rx_valid_p");
        respond_next(16'h1111);
        wait_for(3, "wait_idle_p");

        repeat (10) @(negedge clk);
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/blvds_link_responder.md
BLVDS_LINK_RESPONDER -- requirements
Module: blvds_link_responder

Interface
REQ-001 Parameter CLKS_PER_BIT, default 4, clk cycles per bit, even and at least 4.
REQ-002 Parameter GAP_BITS, default 2, bus-turnaround idle bit periods between command stop bit and response start.
REQ-003 Parameter TIMEOUT_BITS, default 64, bit periods allowed for the response in WAIT_RESP.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 din  in  1  received line level from the BLVDS buffer; asynchronous to clk.
REQ-007 oe  out  1  buffer output enable; 1 = drive p/n, 0 = receive.
REQ-008 doutp  out  1  line level to drive while oe=1.
REQ-009 rx_data  out  16  last valid command word.
REQ-010 rx_valid  out  1  one-cycle pulse; rx_data is new.
REQ-011 rx_err  out  1  one-cycle pulse on framing error.
REQ-012 tmo  out  1  one-cycle pulse on response timeout.
REQ-013 tx_data  in  16  response word.
REQ-014 tx_valid  in  1  response offered.
REQ-015 tx_ready  out  1  response accepted when tx_valid&tx_ready.
REQ-016 busy  out  1  high in every state except IDLE.

Function
REQ-017 Frame: start bit 1, 16 data bits MSB first, stop bit 0; idle line level 0; each bit lasts CLKS_PER_BIT cycles.
REQ-018 din passes through a 2-flop synchronizer; only the synchronized value (dsync) is used; din is ignored while oe=1.
REQ-019 States: IDLE, RX_BITS, WAIT_RESP, GAP, TX_BITS.
REQ-020 IDLE: a dsync 0->1 transition starts a bit counter; at count CLKS_PER_BIT/2, dsync=1 enters RX_BITS; dsync=0 is a glitch and returns to IDLE silently.
REQ-021 RX_BITS: 16 data bits and the stop bit are sampled every CLKS_PER_BIT cycles after the start mid-point, so each sample falls at mid-bit.
REQ-022 Stop sample 0: rx_data is loaded and rx_valid pulses in the same cycle, then WAIT_RESP; stop sample 1: rx_err pulses, rx_data is unchanged, next state IDLE.
REQ-023 WAIT_RESP: tx_ready=1 (0 in all other states); a handshake latches tx_data and enters GAP; if TIMEOUT_BITS*CLKS_PER_BIT cycles pass with no handshake, tmo pulses and the state returns to IDLE.
REQ-024 A handshake on the same cycle as the timeout expiry wins: no tmo, enter GAP.
REQ-025 GAP: oe=0 for GAP_BITS*CLKS_PER_BIT cycles, then TX_BITS.
REQ-026 TX_BITS: oe=1 for exactly 18*CLKS_PER_BIT cycles, with doutp = start 1, data MSB first, stop 0; then oe=0 and IDLE on the next cycle.
REQ-027 doutp=0 whenever oe=0.
REQ-028 oe, doutp, tx_ready, busy, rx_valid, rx_err and tmo are registered outputs.

Reset
REQ-029 While rst=1 and on the first cycle after rst falls: state IDLE, oe=0, doutp=0, tx_ready=0, busy=0, rx_valid=rx_err=tmo=0, rx_data=16'h0000, counters and synchronizer cleared.
REQ-030 rst asserted in any state, including mid-TX_BITS, forces oe=0 on the next clk edge and discards any partial frame or latched response.

Verification
REQ-031 CLKS_PER_BIT=4: drive command 16'hA5C3 with a valid frame -> rx_valid single pulse, rx_data=16'hA5C3, tx_ready=1 next cycle.
REQ-032 Respond tx_data=16'h3C5A on the first tx_ready cycle -> oe=0 for 8 cycles, then oe=1 for 72 cycles with doutp pattern 1,0011110001011010,0 at 4 cycles per bit, then oe=0, busy=0.
REQ-033 Command with stop bit 1 -> rx_err pulse, no rx_valid, rx_data keeps its prior value, state IDLE.
REQ-034 2-cycle high glitch on din in IDLE -> no state change, busy stays 0.
REQ-035 Valid command, tx_valid held 0 -> tmo pulse exactly 256 cycles after tx_ready rises, tx_ready=0 afterward; repeat with tx_valid rising on the expiry cycle -> no tmo, GAP entered.
REQ-036 rst=1 for one cycle during the 5th data bit of TX -> oe=0 and doutp=0 on the next edge; a new command afterward is received normally.
